// File: rtl/jt49_seq_pkg.sv
// Shared definitions for the jt49 register-write sequencer: command opcodes and FSM states.
// Latency: n/a. Backpressure: n/a.
package jt49_seq_pkg;

    localparam logic [1:0] OP_WR   = 2'b00;
    localparam logic [1:0] OP_RD   = 2'b01;
    localparam logic [1:0] OP_WAIT = 2'b10;
    localparam logic [1:0] OP_NOP  = 2'b11;

    // Envelope shape register: every write to it restarts the envelope.
    localparam logic [3:0] REG_ENV_SHAPE = 4'd13;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_GAP,
        ST_RD,
        ST_WAIT
    } seq_state_t;

endpackage

// File: rtl/jt49_seq_shadow.sv
// Shadow of the 16 PSG registers with write port and equality compare (JT49_SEQ_SHADOW_EN).
// Latency: write 1 cycle, compare combinational. Backpressure: none.
// Without the macro it reports no hit, so every write reaches the bus.
module jt49_seq_shadow (
    input  logic       clk,
    input  logic       rst,
    input  logic       we,
    input  logic [3:0] waddr,
    input  logic [7:0] wdata,
    input  logic [3:0] cmp_addr,
    input  logic [7:0] cmp_data,
    output logic       hit
);

`ifdef JT49_SEQ_SHADOW_EN
    logic [7:0] mem [16];

    // Cleared on reset so it tracks the PSG, which is reset alongside.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign hit = (mem[cmp_addr] == cmp_data);
`else
    wire unused_shadow = ^{clk, rst, we, waddr, wdata, cmp_addr, cmp_data};
    assign hit = 1'b0;
`endif

endmodule

// File: rtl/jt49_seq.sv
// jt49 PSG bus master: executes write/read/wait commands with shaped cs_n/wr_n strobes.
// Latency: write WR_HOLD+2 cycles, read 3 cycles, wait N ticks + 1. Optional JT49_SEQ_SHADOW_EN drops redundant writes.
// Backpressure: cmd_ready is high only in IDLE; a command is taken on cmd_valid & cmd_ready.
module jt49_seq
    import jt49_seq_pkg::*;
#(
    parameter int WR_HOLD = 2,
    parameter int DLY_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [3:0]       cmd_addr,
    input  logic [DLY_W-1:0] cmd_data,
    input  logic             tick,
    output logic [3:0]       psg_addr,
    output logic [7:0]       psg_din,
    output logic             psg_cs_n,
    output logic             psg_wr_n,
    input  logic [7:0]       psg_dout,
    output logic             rd_valid,
    output logic [7:0]       rd_data,
    output logic             busy
);

    localparam logic [DLY_W-1:0] CNT_ONE   = DLY_W'(1);
    localparam logic [DLY_W-1:0] HOLD_LAST = DLY_W'(WR_HOLD - 1);

    seq_state_t       state, state_nxt;
    logic [DLY_W-1:0] cnt;
    logic             accept;
    logic             shadow_hit;
    logic             wr_drop;
    logic             wr_issue;
    logic             rd_done;

    assign cmd_ready = (state == ST_IDLE);
    assign busy      = ~cmd_ready;
    assign accept    = cmd_valid & cmd_ready;

    // Envelope shape writes always go out: the write edge itself restarts the envelope.
    assign wr_drop  = shadow_hit && (cmd_addr != REG_ENV_SHAPE);
    assign wr_issue = accept && (cmd_op == OP_WR) && !wr_drop;
    assign rd_done  = (state == ST_RD) && (state_nxt == ST_IDLE);

    jt49_seq_shadow u_shadow (
        .clk      (clk),
        .rst      (rst),
        .we       (wr_issue),
        .waddr    (cmd_addr),
        .wdata    (cmd_data[7:0]),
        .cmp_addr (cmd_addr),
        .cmp_data (cmd_data[7:0]),
        .hit      (shadow_hit)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    case (cmd_op)
                        OP_WR:   state_nxt = wr_drop ? ST_IDLE : ST_WR;
                        OP_RD:   state_nxt = ST_RD;
                        OP_WAIT: state_nxt = (cmd_data != '0) ? ST_WAIT : ST_IDLE;
                        default: state_nxt = ST_IDLE;
                    endcase
                end
            end
            ST_WR:   if (cnt == '0) state_nxt = ST_GAP;
            ST_GAP:  state_nxt = ST_IDLE;
            ST_RD:   if (cnt == '0) state_nxt = ST_IDLE;
            ST_WAIT: if (tick && (cnt <= CNT_ONE)) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Strobes are registered from the next state so they change exactly on state entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            psg_addr <= '0;
            psg_din  <= '0;
            psg_cs_n <= 1'b1;
            psg_wr_n <= 1'b1;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            state    <= state_nxt;
            psg_cs_n <= !((state_nxt == ST_WR) || (state_nxt == ST_RD));
            psg_wr_n <= !(state_nxt == ST_WR);
            rd_valid <= rd_done;
            if (rd_done) rd_data <= psg_dout;

            case (state)
                ST_IDLE: begin
                    if (wr_issue) begin
                        psg_addr <= cmd_addr;
                        psg_din  <= cmd_data[7:0];
                        cnt      <= HOLD_LAST;
                    end else if (accept && (cmd_op == OP_RD)) begin
                        psg_addr <= cmd_addr;
                        cnt      <= CNT_ONE;
                    end else if (accept && (cmd_op == OP_WAIT)) begin
                        cnt      <= cmd_data;
                    end
                end
                ST_WR, ST_RD: if (cnt != '0) cnt <= cnt - CNT_ONE;
                ST_WAIT:      if (tick) cnt <= cnt - CNT_ONE;
                default: ;
            endcase
        end
    end

endmodule
